// File: rtl/rasterizer_pkg.sv
// Shared rasterizer types and divider widths used by the divider arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rasterizer_pkg;

    localparam int DIV_DOUT_W    = 88;
    localparam int DIV_OPERAND_W = 64;

    // Arbiter control state: normal issue, or draining in-flight divisions.
    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight division.
// Latency: 1 cycle push-to-visible; head (dout) is read combinationally.
// Backpressure: pushes while full and pops while empty are ignored; count/full/empty are registered.
// Ports: clk, rst (async, active-high), push/din, pop/dout, full, empty, count.
module tag_fifo #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin share of one divider core among N_REQ requesters; results routed back by in-order tag.
// Latency: 0 cycles added each way (combinational request/response muxes); outstanding is registered.
// Backpressure: issue stalls on full tag FIFO, S_DRAIN or div_s_ready low; div_m_ready follows the head owner's resp_ready.
// Ports: req_* (requesters in), resp_* (results out), div_s_*/div_m_* (divider), flush_req/flush_done,
//        busy, outstanding, err_orphan, stat_issued. Optional macro DIV_ARB_STATS_EN builds issue counters.
module div_arbiter
    import rasterizer_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int TAG_DEPTH = 8,
    parameter int DOUT_W    = DIV_DOUT_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_REQ-1:0]                       req_valid,
    output logic [N_REQ-1:0]                       req_ready,
    input  logic [N_REQ-1:0][DIV_OPERAND_W-1:0]    req_divisor,
    input  logic [N_REQ-1:0][DIV_OPERAND_W-1:0]    req_dividend,
    output logic [N_REQ-1:0]                       resp_valid,
    input  logic [N_REQ-1:0]                       resp_ready,
    output logic [DOUT_W-1:0]                      resp_data,
    output logic                                   resp_dbz,
    output logic                                   div_s_valid,
    input  logic                                   div_s_ready,
    output logic [DIV_OPERAND_W-1:0]               div_divisor,
    output logic [DIV_OPERAND_W-1:0]               div_dividend,
    input  logic                                   div_m_valid,
    input  logic [DOUT_W-1:0]                      div_m_data,
    input  logic                                   div_m_dbz,
    output logic                                   div_m_ready,
    input  logic                                   flush_req,
    output logic                                   flush_done,
    output logic                                   busy,
    output logic [$clog2(TAG_DEPTH):0]             outstanding,
    output logic                                   err_orphan,
    output logic [N_REQ-1:0][31:0]                 stat_issued
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic [IW-1:0]           rr_ptr;
    logic [IW-1:0]           gnt_idx;
    logic                    gnt_found;
    logic [IW:0]             cand;
    logic                    issue_en;
    logic                    fire;
    logic                    pop;
    logic [IW-1:0]           head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(TAG_DEPTH):0] fifo_count;

    tag_fifo #(
        .WIDTH (IW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fire),
        .din   (gnt_idx),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN:   if (flush_req) state_nxt = S_DRAIN;
            S_DRAIN: if (fifo_count == '0) state_nxt = S_RUN;
            default: state_nxt = S_RUN;
        endcase
    end

    // Full blocks issue even when a pop lands in the same cycle.
    always_comb begin
        issue_en   = (state == S_RUN) && !fifo_full;
        flush_done = (state == S_DRAIN) && (fifo_count == '0);
        busy       = (fifo_count != '0) || (state == S_DRAIN);
    end

    // ---------------- request side ----------------
    // First valid requester at or after rr_ptr, wrapping at N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
            if (!gnt_found && req_valid[cand[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        div_s_valid  = issue_en && gnt_found;
        div_divisor  = req_divisor[gnt_idx];
        div_dividend = req_dividend[gnt_idx];
        req_ready    = '0;
        if (div_s_valid) req_ready[gnt_idx] = div_s_ready;
        fire         = div_s_valid && div_s_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (fire) begin
            rr_ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    // ---------------- response side ----------------
    // With no tag outstanding a result has no owner: accept and drop it.
    always_comb begin
        resp_valid  = '0;
        div_m_ready = 1'b1;
        if (!fifo_empty) begin
            div_m_ready      = resp_ready[head];
            resp_valid[head] = div_m_valid;
        end
        resp_data = div_m_data;
        resp_dbz  = div_m_dbz;
        pop       = div_m_valid && div_m_ready && !fifo_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             err_orphan <= 1'b0;
        else if (div_m_valid && fifo_empty)  err_orphan <= 1'b1;
    end

    assign outstanding = fifo_count;

    // ---------------- optional issue statistics ----------------
`ifdef DIV_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (fire && (gnt_idx == IW'(i))) stat_issued[i] <= stat_issued[i] + 32'd1;
            end
        end
    end
`else
    assign stat_issued = '0;
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a latency-5 divider stub and a queue-based reference model.
// Latency: n/a.
// Backpressure: stub can stall its result channel; resp_ready driven per requester.
module tb_div_arbiter;
    localparam int N   = 2;
    localparam int D   = 2;
    localparam int DW  = 88;
    localparam int LAT = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0][63:0] req_divisor;
    logic [N-1:0][63:0] req_dividend;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [DW-1:0]     resp_data;
    logic              resp_dbz;
    logic              div_s_valid;
    logic              div_s_ready;
    logic [63:0]       div_divisor;
    logic [63:0]       div_dividend;
    logic              div_m_valid;
    logic [DW-1:0]     div_m_data;
    logic              div_m_dbz;
    logic              div_m_ready;
    logic              flush_req;
    logic              flush_done;
    logic              busy;
    logic [1:0]        outstanding;
    logic              err_orphan;
    logic [N-1:0][31:0] stat_issued;

    div_arbiter #(.N_REQ(N), .TAG_DEPTH(D), .DOUT_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_divisor(req_divisor), .req_dividend(req_dividend),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_dbz(resp_dbz),
        .div_s_valid(div_s_valid), .div_s_ready(div_s_ready),
        .div_divisor(div_divisor), .div_dividend(div_dividend),
        .div_m_valid(div_m_valid), .div_m_data(div_m_data),
        .div_m_dbz(div_m_dbz), .div_m_ready(div_m_ready),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
        .outstanding(outstanding), .err_orphan(err_orphan),
        .stat_issued(stat_issued)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] quot(input logic [63:0] dvs, input logic [63:0] dvd);
        return (dvs == 64'd0) ? '1 : dvd / dvs;
    endfunction

    // ---------------- reference model state ----------------
    int          m_rr;
    bit          m_drain;
    int          m_tags[$];
    logic [63:0] m_quot[$];
    bit          m_orphan;
    int unsigned m_stat[N];
    // observation logs (written only by the monitor)
    int          grant_log[$];
    int          resp_order[$];
    int          rv_cnt[N];
    int          acc_cnt[N];
    int          max_out;
    // handshake hand-off to the stub
    bit          hs_push, hs_pop;
    logic [63:0] hs_dvs, hs_dvd;

    always @(negedge clk) begin
        int g, h, idx, pre;
        logic [N-1:0] e_rdy, e_rv;
        logic e_mrdy;
        bit fire;
        logic [31:0] e_stat;
        if (rst) begin
            m_rr = 0; m_drain = 0; m_orphan = 0;
            m_tags.delete(); m_quot.delete();
            for (int i = 0; i < N; i++) m_stat[i] = 0;
            hs_push = 0; hs_pop = 0;
        end else begin
            g = -1;
            pre = m_tags.size();
            if (!m_drain && pre < D) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            chk("div_s_valid", div_s_valid, g >= 0);
            e_rdy = '0;
            if (g >= 0 && div_s_ready) e_rdy[g] = 1'b1;
            chk("req_ready", req_ready, e_rdy);
            if (g >= 0) begin
                chk("div_divisor", div_divisor, req_divisor[g]);
                chk("div_dividend", div_dividend, req_dividend[g]);
            end
            e_rv = '0;
            e_mrdy = 1'b1;
            if (pre > 0) begin
                h = m_tags[0];
                e_mrdy = resp_ready[h];
                if (div_m_valid) e_rv[h] = 1'b1;
            end
            chk("resp_valid", resp_valid, e_rv);
            chk("div_m_ready", div_m_ready, e_mrdy);
            if (e_rv != '0) begin
                chk("resp_data", resp_data, div_m_data);
                chk("resp_dbz", resp_dbz, div_m_dbz);
            end
            chk("outstanding", outstanding, pre);
            chk("busy", busy, (pre != 0) || m_drain);
            chk("flush_done", flush_done, m_drain && pre == 0);
            chk("err_orphan", err_orphan, m_orphan);
            for (int i = 0; i < N; i++) begin
`ifdef DIV_ARB_STATS_EN
                e_stat = m_stat[i];
`else
                e_stat = 32'd0;
`endif
                chk("stat_issued", stat_issued[i], e_stat);
            end
            // logs
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i]) rv_cnt[i]++;
                if (resp_valid[i] && resp_ready[i]) acc_cnt[i]++;
            end
            if (pre > max_out) max_out = pre;
            // advance model to post-edge state
            fire = (g >= 0) && div_s_ready;
            if (m_drain) begin
                if (pre == 0) m_drain = 0;
            end else if (flush_req) begin
                m_drain = 1;
            end
            if (div_m_valid && pre == 0) m_orphan = 1;
            if (div_m_valid && e_mrdy && pre > 0) begin
                chk("resp_quot", resp_data[63:0], m_quot[0]);
                resp_order.push_back(m_tags[0]);
                void'(m_tags.pop_front());
                void'(m_quot.pop_front());
            end
            if (fire) begin
                grant_log.push_back(g);
                m_tags.push_back(g);
                m_quot.push_back(quot(req_divisor[g], req_dividend[g]));
                m_rr = (g + 1) % N;
                m_stat[g]++;
            end
            hs_push = div_s_valid && div_s_ready;
            hs_dvs  = div_divisor;
            hs_dvd  = div_dividend;
            hs_pop  = div_m_valid && div_m_ready;
        end
    end

    // ---------------- divider stub ----------------
    typedef struct {
        int           rdy;
        logic [DW-1:0] d;
        logic         z;
    } job_t;
    job_t sq[$];
    int   scyc = 0;
    int   seqn = 0;
    int   inj_req = 0;
    int   inj_ack = 0;
    bit   stub_stall;

    always begin
        job_t j;
        @(posedge clk);
        #2;
        scyc++;
        if (rst) begin
            sq.delete();
            div_m_valid = 1'b0;
            div_m_data  = '0;
            div_m_dbz   = 1'b0;
        end else begin
            if (hs_pop && sq.size() > 0 && div_m_valid) void'(sq.pop_front());
            if (hs_push) begin
                j.rdy = scyc + LAT;
                j.d   = {24'(seqn), quot(hs_dvs, hs_dvd)};
                j.z   = (hs_dvs == 64'd0);
                seqn++;
                sq.push_back(j);
            end
            div_m_valid = 1'b0;
            if (inj_req != inj_ack) begin
                inj_ack++;
                div_m_valid = 1'b1;
                div_m_data  = 88'hBAD;
                div_m_dbz   = 1'b0;
            end else if (!stub_stall && sq.size() > 0 && sq[0].rdy <= scyc) begin
                div_m_valid = 1'b1;
                div_m_data  = sq[0].d;
                div_m_dbz   = sq[0].z;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int r, input logic [63:0] dvs, input logic [63:0] dvd);
        bit ok = 0;
        @(posedge clk); #1;
        req_divisor[r]  = dvs;
        req_dividend[r] = dvd;
        req_valid[r]    = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready[r]) begin ok = 1; break; end
        end
        chk("issue_handshake", ok, 1);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_resp(input int r, output logic [63:0] q);
        bit ok = 0;
        q = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (resp_valid[r] && resp_ready[r]) begin ok = 1; q = resp_data[63:0]; break; end
        end
        chk("resp_arrives", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        repeat (2) @(negedge clk);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (outstanding == 0 && !div_m_valid) begin ok = 1; break; end
        end
        chk("idle_reached", ok, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] q, d0;
        int base, rv1, pulses, early, acc0, acc1;
        bit got;
        rst = 1'b1;
        req_valid = '0; req_divisor = '0; req_dividend = '0;
        resp_ready = '1; div_s_ready = 1'b1; flush_req = 1'b0;
        stub_stall = 1'b0;
        div_m_valid = 1'b0; div_m_data = '0; div_m_dbz = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_div_s_valid", div_s_valid, 0);
        chk("rst_div_m_ready", div_m_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_err_orphan", err_orphan, 0);
        chk("rst_stat", stat_issued, 0);
        @(posedge clk); #1 rst = 1'b0;

        // single requester: 65536 / 4
        #1 rv1 = rv_cnt[1];
        issue(0, 64'd4, 64'd65536);
        wait_resp(0, q);
        chk("single_quot", q, 64'd16384);
        wait_idle();
        #1;
        chk("single_no_resp1", rv_cnt[1] - rv1, 0);
        chk("single_outstanding", outstanding, 0);

        // contention after reset: grants 0,1,0,1
        pulse_reset();
        #1 base = grant_log.size(); acc0 = acc_cnt[0]; acc1 = acc_cnt[1];
        @(posedge clk); #1;
        req_divisor[0] = 64'd10; req_dividend[0] = 64'd100;
        req_divisor[1] = 64'd3;  req_dividend[1] = 64'd99;
        req_valid = 2'b11;
        got = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk); #1;
            if (grant_log.size() >= base + 4) begin got = 1; break; end
        end
        chk("contention_fires", got, 1);
        @(posedge clk); #1 req_valid = '0;
        wait_idle();
        #1;
        if (got) begin
            chk("grant0", grant_log[base],   0);
            chk("grant1", grant_log[base+1], 1);
            chk("grant2", grant_log[base+2], 0);
            chk("grant3", grant_log[base+3], 1);
        end
        chk("contention_acc0", acc_cnt[0] - acc0, 2);
        chk("contention_acc1", acc_cnt[1] - acc1, 2);

        // response backpressure on requester 1
        @(posedge clk); #1 resp_ready[1] = 1'b0;
        issue(1, 64'd7, 64'd70);
        issue(0, 64'd5, 64'd55);
        got = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (resp_valid[1]) begin got = 1; break; end
        end
        chk("bp_head_seen", got, 1);
        d0 = resp_data[63:0];
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            chk("bp_m_ready", div_m_ready, 0);
            chk("bp_data_held", resp_data[63:0], d0);
        end
        @(posedge clk); #1 resp_ready[1] = 1'b1;
        wait_resp(1, q);
        chk("bp_first", q, 64'd10);
        wait_resp(0, q);
        chk("bp_second", q, 64'd11);
        wait_idle();

        // FIFO full: third request held off until the first pop
        @(posedge clk); #1 stub_stall = 1'b1;
        issue(0, 64'd2, 64'd8);
        issue(1, 64'd2, 64'd10);
        @(posedge clk); #1;
        req_divisor[0] = 64'd2; req_dividend[0] = 64'd12; req_valid[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("full_req_ready", req_ready, 0);
            chk("full_outstanding", outstanding, 2);
        end
        @(posedge clk); #1 stub_stall = 1'b0;
        got = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready[0]) begin got = 1; break; end
        end
        chk("full_third_issued", got, 1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_idle();
        #1 chk("full_peak", max_out, 2);

        // flush with two divisions in flight
        @(posedge clk); #1 stub_stall = 1'b1;
        issue(0, 64'd1, 64'd5);
        issue(1, 64'd1, 64'd6);
        @(posedge clk); #1;
        flush_req = 1'b1;
        req_divisor[0] = 64'd3; req_dividend[0] = 64'd9; req_valid[0] = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0; stub_stall = 1'b0;
        pulses = 0; early = 0; got = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (flush_done) pulses++;
            if (div_s_valid && pulses == 0) early++;
            if (req_ready[0]) begin got = 1; break; end
        end
        chk("flush_pulses", pulses, 1);
        chk("flush_no_early_issue", early, 0);
        chk("flush_resume", got, 1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_idle();

        // flush while idle: one-cycle drain
        @(posedge clk); #1 flush_req = 1'b1;
        @(negedge clk);
        chk("idle_flush_c0_done", flush_done, 0);
        @(posedge clk); #1 flush_req = 1'b0;
        @(negedge clk);
        chk("idle_flush_c1_done", flush_done, 1);
        chk("idle_flush_c1_busy", busy, 1);
        @(negedge clk);
        chk("idle_flush_c2_done", flush_done, 0);
        chk("idle_flush_c2_busy", busy, 0);

        // orphan result then three issues from requester 1
        pulse_reset();
        @(posedge clk); #1 inj_req++;
        repeat (2) @(negedge clk);
        chk("orphan_set", err_orphan, 1);
        issue(1, 64'd6, 64'd60);
        issue(1, 64'd6, 64'd61);
        issue(1, 64'd0, 64'd62);
        wait_idle();
        chk("orphan_sticky", err_orphan, 1);
`ifdef DIV_ARB_STATS_EN
        chk("stat_req1", stat_issued[1], 3);
`else
        chk("stat_req1", stat_issued[1], 0);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
